iter_shift_unit: RTL and testbench

//  Parametrised multi-cycle shift/decode unit for the integer datapath. Executes SLL,
//  SRL and SRA, plus DEC, a one-hot decode producing 1<<shamt (generalises the 5-to-32
//  one-hot decoder to any XLEN). Shifts at most STEP bit positions per clock, so a wide

---
 rtl/iter_shift_unit.sv | 170 +++++++++++++++++
 tb/tb_iter_shift_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_unit.sv
// ---------------------------------------------------------------------------
// iter_shift_unit
//
// Multi-cycle shift/decode unit for the integer datapath. Performs SLL, SRL,
// SRA and DEC (one-hot decode, 1 << shamt) while moving the operand by at
// most STEP bit positions per clock, so only a narrow shifter is built.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous reset, active-high
//   flush      in   1     synchronous abort of any in-flight operation
//   in_valid   in   1     command valid
//   in_ready   out  1     unit idle and able to accept a command
//   in_op      in   2     00 SLL, 01 SRL, 11 SRA, 10 DEC
//   in_data    in   XLEN  operand (ignored for DEC)
//   in_shamt   in   SHW   unsigned shift amount
//   out_valid  out  1     result valid
//   out_ready  in   1     consumer accepts result
//   out_data   out  XLEN  result
// ---------------------------------------------------------------------------
module iter_shift_unit #(
    parameter int XLEN = 32,
    parameter int STEP = 8,
    localparam int SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_data,
    input  logic [SHW-1:0]  in_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // STEP may equal XLEN, which does not fit in SHW bits, so the per-cycle
    // limit is held one bit wider than the remaining-count register.
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      op_q;
    logic [1:0]      op_next;
    logic [XLEN-1:0] data_q;
    logic [XLEN-1:0] data_next;
    logic [SHW-1:0]  rem_q;
    logic [SHW-1:0]  rem_next;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] res_next;

    logic [SHW-1:0]  amt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    // Amount moved this cycle: whatever is left, capped at STEP.
    always_comb begin
        if ({1'b0, rem_q} < STEP_W) begin
            amt = rem_q;
        end else begin
            amt = STEP_W[SHW-1:0];
        end
    end

    // One narrow step of the working operand. DEC is a left shift of a
    // single seeded 1, so it shares the SLL path.
    always_comb begin
        case (op_q)
            OP_SRL:  shifted = data_q >> amt;
            OP_SRA:  shifted = $unsigned($signed(data_q) >>> amt);
            default: shifted = data_q << amt;
        endcase
    end

    // Operand captured on accept; DEC ignores in_data and starts from 1.
    always_comb begin
        if (in_op == OP_DEC) begin
            load_data = {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            load_data = in_data;
        end
    end

    // Next-state logic. The result register is only written when an
    // operation finishes, so the consumer never sees intermediate values
    // and a flushed operation leaves the previous result on out_data.
    always_comb begin
        state_next = state;
        op_next    = op_q;
        data_next  = data_q;
        rem_next   = rem_q;
        res_next   = res_q;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_next   = in_op;
                    data_next = load_data;
                    rem_next  = in_shamt;
                    if (in_shamt == '0) begin
                        state_next = DONE;
                        res_next   = load_data;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_next = shifted;
                rem_next  = rem_q - amt;
                if (rem_q == amt) begin
                    state_next = DONE;
                    res_next   = shifted;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort wins over accept and over the output handshake.
        if (flush) begin
            state_next = IDLE;
            op_next    = op_q;
            data_next  = data_q;
            rem_next   = rem_q;
            res_next   = res_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            data_q <= '0;
            rem_q  <= '0;
            res_q  <= '0;
        end else begin
            state  <= state_next;
            op_q   <= op_next;
            data_q <= data_next;
            rem_q  <= rem_next;
            res_q  <= res_next;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = res_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_shift_unit
//
// Drives three copies of iter_shift_unit (STEP = 8, 1 and 32) with the same
// command stream and checks result, latency and handshake behaviour of each.
// ---------------------------------------------------------------------------
module tb_iter_shift_unit;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_data;
    logic [SHW-1:0]  in_shamt;
    logic            out_ready;

    logic            in_ready_a, in_ready_b, in_ready_c;
    logic            out_valid_a, out_valid_b, out_valid_c;
    logic [XLEN-1:0] out_data_a, out_data_b, out_data_c;

    int checks   = 0;
    int failures = 0;

    // Unit a: STEP 8, unit b: STEP 1, unit c: STEP 32.
    iter_shift_unit #(.XLEN(XLEN), .STEP(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_op(in_op),
        .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
    );

    iter_shift_unit #(.XLEN(XLEN), .STEP(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_op(in_op),
        .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
    );

    iter_shift_unit #(.XLEN(XLEN), .STEP(32)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_op(in_op),
        .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Reference result computed in one go, independent of step size.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d,
                                          input logic [4:0] s);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b11:   r = $unsigned($signed(d) >>> s);
            default: r = 32'h1 << s;
        endcase
        return r;
    endfunction

    function automatic int expLat(input int s, input int step);
        return 1 + (s + step - 1) / step;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one command for a single edge, then scramble the inputs so
    // that any late sampling shows up as a wrong result. Returns 1 time
    // unit after the accept edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = ~op;
        in_data  = ~d;
        in_shamt = ~s;
    endtask

    // Wait (bounded) until every unit shows out_valid; records the edge
    // count from the accept edge and whether in_ready stayed low while busy.
    task automatic waitAll(output int la, output int lb, output int lc, output bit busy_ok);
        la = 0; lb = 0; lc = 0; busy_ok = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (out_valid_a && la == 0) la = cyc;
            if (out_valid_b && lb == 0) lb = cyc;
            if (out_valid_c && lc == 0) lc = cyc;
            if ((!out_valid_a && in_ready_a) || (!out_valid_b && in_ready_b) ||
                (!out_valid_c && in_ready_c)) busy_ok = 1'b0;
            if (la != 0 && lb != 0 && lc != 0) break;
            @(posedge clk);
            #1;
        end
    endtask

    // Consume the result from all units and confirm they return to idle.
    task automatic releaseAll(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " idle valid"}, {29'd0, out_valid_a, out_valid_b, out_valid_c}, 32'd0);
        checkOutput({tag, " idle ready"}, {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'd7);
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp, input string tag);
        int  la, lb, lc;
        bit  busy_ok;
        applyStimulus(op, d, s);
        waitAll(la, lb, lc, busy_ok);
        checkOutput({tag, " data s8"},  out_data_a, exp);
        checkOutput({tag, " data s1"},  out_data_b, exp);
        checkOutput({tag, " data s32"}, out_data_c, exp);
        checkOutput({tag, " lat s8"},  32'(la), 32'(expLat(int'(s), 8)));
        checkOutput({tag, " lat s1"},  32'(lb), 32'(expLat(int'(s), 1)));
        checkOutput({tag, " lat s32"}, 32'(lc), 32'(expLat(int'(s), 32)));
        checkOutput({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        releaseAll(tag);
    endtask

    initial begin
        logic [31:0] hold;
        int          la, lb, lc;
        bit          busy_ok;
        bit          stable;

        vecs[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1]  = '{2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2]  = '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 5'd5,  32'h0000_0020};
        vecs[4]  = '{2'b10, 32'hA5A5_A5A5, 5'd0,  32'h0000_0001};
        vecs[5]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[6]  = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[7]  = '{2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[8]  = '{2'b11, 32'h7FFF_FFFF, 5'd8,  32'h007F_FFFF};
        vecs[9]  = '{2'b00, 32'h1234_5678, 5'd8,  32'h3456_7800};
        vecs[10] = '{2'b01, 32'h1234_5678, 5'd9,  32'h0009_1A2B};
        vecs[11] = '{2'b11, 32'hF000_0000, 5'd16, 32'hFFFF_F000};
        vecs[12] = '{2'b10, 32'h0000_0000, 5'd31, 32'h8000_0000};
        vecs[13] = '{2'b00, 32'hFFFF_FFFF, 5'd17, 32'hFFFE_0000};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset ready", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'd7);
        checkOutput("reset valid", {29'd0, out_valid_a, out_valid_b, out_valid_c}, 32'd0);
        checkOutput("reset data",  out_data_a | out_data_b | out_data_c, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            runOp(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Full DEC sweep.
        for (int s = 0; s < 32; s++) begin
            runOp(2'b10, 32'h5555_5555, 5'(s), 32'h1 << s, $sformatf("dec%0d", s));
        end

        // Result held for 10 stalled cycles, then released.
        applyStimulus(2'b01, 32'hFFFF_FFFF, 5'd13);
        waitAll(la, lb, lc, busy_ok);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid_a || out_data_a !== 32'h0007_FFFF) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        checkOutput("stall stable", {31'd0, stable}, 32'd1);
        checkOutput("stall data", out_data_a, 32'h0007_FFFF);
        releaseAll("stall");

        // Asynchronous reset in the middle of a shift.
        applyStimulus(2'b00, 32'h0000_0003, 5'd31);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst valid", {29'd0, out_valid_a, out_valid_b, out_valid_c}, 32'd0);
        checkOutput("arst ready", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'd7);
        checkOutput("arst data",  out_data_a | out_data_b | out_data_c, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Flush mid-shift: previous result stays, no valid ever appears.
        runOp(2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, "preflush");
        applyStimulus(2'b00, 32'hDEAD_BEEF, 5'd31);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush ready", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'd7);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_a || out_valid_b || out_valid_c) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        checkOutput("flush novalid", {31'd0, stable}, 32'd1);
        checkOutput("flush keep", out_data_a, 32'h0000_0010);

        // Flush beats an accept in the same cycle.
        in_valid = 1'b1;
        in_op    = 2'b10;
        in_shamt = 5'd0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flushacc valid", {29'd0, out_valid_a, out_valid_b, out_valid_c}, 32'd0);
        checkOutput("flushacc ready", {29'd0, in_ready_a, in_ready_b, in_ready_c}, 32'd7);
        checkOutput("flushacc keep", out_data_a, 32'h0000_0010);

        // Flush in DONE together with out_ready: result kept, back to idle.
        applyStimulus(2'b11, 32'h8765_4321, 5'd12);
        waitAll(la, lb, lc, busy_ok);
        checkOutput("doneflush data", out_data_a, 32'hFFF8_7654);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        checkOutput("doneflush valid", {29'd0, out_valid_a, out_valid_b, out_valid_c}, 32'd0);
        checkOutput("doneflush keep", out_data_c, 32'hFFF8_7654);

        // Random commands against the reference model.
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  rop;
            logic [31:0] rd;
            logic [4:0]  rs;
            rop  = 2'($urandom_range(0, 3));
            rd   = $urandom;
            rs   = 5'($urandom_range(0, 31));
            hold = model(rop, rd, rs);
            runOp(rop, rd, rs, hold, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
